// File: rtl/trap_pkg.sv
// Shared encodings for the trap sequencer: request kinds, mcause codes and FSM states.
package trap_pkg;

  localparam int unsigned KIND_W  = 2;
  localparam int unsigned CAUSE_W = 4;

  localparam int unsigned CAUSE_ILLEGAL    = 2;
  localparam int unsigned CAUSE_BREAKPOINT = 3;
  localparam int unsigned CAUSE_ECALL_M    = 11;

  typedef enum logic [KIND_W-1:0] {
    KIND_ECALL   = 2'b00,
    KIND_EBREAK  = 2'b01,
    KIND_MRET    = 2'b10,
    KIND_ILLEGAL = 2'b11
  } trap_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_COMMIT   = 2'b01,
    ST_REDIRECT = 2'b10
  } trap_state_t;

  // mcause code for a trapping kind; MRET has no cause.
  function automatic logic [CAUSE_W-1:0] cause_of(input trap_kind_t kind);
    logic [CAUSE_W-1:0] cause;
    cause = '0;
    case (kind)
      KIND_ECALL:   cause = CAUSE_W'(CAUSE_ECALL_M);
      KIND_EBREAK:  cause = CAUSE_W'(CAUSE_BREAKPOINT);
      KIND_ILLEGAL: cause = CAUSE_W'(CAUSE_ILLEGAL);
      default:      cause = '0;
    endcase
    return cause;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Trap sequencer: commits ECALL/EBREAK/ILLEGAL to the CSR file, then redirects fetch to mtvec or mepc.
// Define TRAP_ILLEGAL_EN to make kind 11 trap with cause 2; otherwise it is consumed silently.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            exception,
  output logic [XLEN-1:0] exception_pc,
  output logic [XLEN-1:0] exception_cause,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  // Direct mode only: the mode field of mtvec never reaches fetch.
  localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  trap_state_t     r_state;
  logic            r_req_ready;
  logic            r_busy;
  logic            r_exception;
  logic [XLEN-1:0] r_exception_pc;
  logic [XLEN-1:0] r_exception_cause;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  trap_kind_t      w_kind;
  logic            w_start_trap;
  logic            w_start_mret;

  assign w_kind = trap_kind_t'(req_kind);

  // Classify a request presented in IDLE.
  always_comb begin
    w_start_trap = 1'b0;
    w_start_mret = 1'b0;
    if (r_state == ST_IDLE && req_valid) begin
      case (w_kind)
        KIND_ECALL, KIND_EBREAK: w_start_trap = 1'b1;
        KIND_MRET:               w_start_mret = 1'b1;
        KIND_ILLEGAL: begin
`ifdef TRAP_ILLEGAL_EN
          w_start_trap = 1'b1;
`else
          w_start_trap = 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM; the exception registers double as the latched request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state           <= ST_IDLE;
      r_req_ready       <= 1'b1;
      r_busy            <= 1'b0;
      r_exception       <= 1'b0;
      r_exception_pc    <= '0;
      r_exception_cause <= '0;
      r_redirect_valid  <= 1'b0;
      r_redirect_pc     <= '0;
    end else begin
      r_exception       <= 1'b0;
      r_exception_pc    <= '0;
      r_exception_cause <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_trap) begin
            r_state           <= ST_COMMIT;
            r_req_ready       <= 1'b0;
            r_busy            <= 1'b1;
            r_exception       <= 1'b1;
            r_exception_pc    <= req_pc;
            r_exception_cause <= XLEN'(cause_of(w_kind));
          end else if (w_start_mret) begin
            r_state          <= ST_REDIRECT;
            r_req_ready      <= 1'b0;
            r_busy           <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= csr_mepc;
          end
        end
        ST_COMMIT: begin
          r_state          <= ST_REDIRECT;
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= csr_mtvec & MTVEC_MASK;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            r_state          <= ST_IDLE;
            r_req_ready      <= 1'b1;
            r_busy           <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
          end
        end
        default: begin
          r_state          <= ST_IDLE;
          r_req_ready      <= 1'b1;
          r_busy           <= 1'b0;
          r_redirect_valid <= 1'b0;
          r_redirect_pc    <= '0;
        end
      endcase
    end
  end

  assign req_ready       = r_req_ready;
  assign busy            = r_busy;
  assign exception       = r_exception;
  assign exception_pc    = r_exception_pc;
  assign exception_cause = r_exception_cause;
  assign redirect_valid  = r_redirect_valid;
  assign redirect_pc     = r_redirect_pc;

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer that drives the machine-mode CSR file's exception-commit port and the fetch unit's redirect port. It accepts one trap or return request at a time from the execute stage and pulses the CSR file's `exception`/`exception_pc`/`exception_cause` inputs. It then redirects fetch to the CSR file's `mtvec` output after a trap, or to its `mepc` output after `mret`. It sits between EXU and IFU/CSR, and asserts `busy` to stall the front end while a sequence is in flight.

## Interface
Parameters:
- `XLEN`, default 32: data and address width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  EXU presents a trap or return request.
- `req_ready`  out  1  high only in IDLE.
- `req_kind`  in  2  request kind: 00 ECALL, 01 EBREAK, 10 MRET, 11 ILLEGAL.
- `req_pc`  in  XLEN  PC of the requesting instruction.
- `csr_mtvec`  in  XLEN  current `mtvec` from the CSR file.
- `csr_mepc`  in  XLEN  current `mepc` from the CSR file.
- `exception`  out  1  one-cycle commit pulse to the CSR file.
- `exception_pc`  out  XLEN  value written to `mepc`.
- `exception_cause`  out  XLEN  value written to `mcause`.
- `redirect_valid`  out  1  fetch redirect request.
- `redirect_ready`  in  1  IFU accepts the redirect.
- `redirect_pc`  out  XLEN  new fetch address.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, COMMIT, REDIRECT.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, the request is accepted and `req_pc` and `req_kind` are latched.
  - ECALL, EBREAK or ILLEGAL goes to COMMIT. MRET goes to REDIRECT.
- **COMMIT** (exactly one cycle)
  - `exception`=1, `exception_pc`=latched pc.
  - `exception_cause` is 11 for ECALL, 3 for EBREAK, 2 for ILLEGAL.
  - `csr_mtvec` is sampled this cycle, with bits [1:0] forced to 0 (direct mode only).
  - Next state is REDIRECT.
- **REDIRECT**
  - `redirect_valid`=1.
  - `redirect_pc` is the sampled mtvec for a trap, or `csr_mepc` sampled at MRET accept.
  - Stays in REDIRECT until `redirect_ready`=1, then goes to IDLE.
- `redirect_pc` is held stable while `redirect_valid`=1 and `redirect_ready`=0.
- `exception_pc` and `exception_cause` are 0 whenever `exception`=0.
- Requests arriving while not IDLE are ignored; EXU must hold them, since `req_ready`=0.
- Cause values are zero-extended to XLEN. There is no interrupt bit; bit XLEN-1 is always 0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `exception`=0, `exception_pc`=0, `exception_cause`=0, `redirect_valid`=0, `redirect_pc`=0.
- Trap latency: request accepted at edge T. `exception` is high in cycle T+1, so the CSR file updates at edge T+2. `redirect_valid` rises in cycle T+2.
- MRET latency: `redirect_valid` is high in cycle T+1.
- With `redirect_ready` tied high:
  - a trap occupies 2 cycles after accept;
  - MRET occupies 1 cycle after accept;
  - a new request can be accepted in the cycle after the handshake.
- Reset (`rst_n`=0) in any state returns the block to IDLE at that edge. Outputs take reset values and any pending `exception` pulse is dropped.
- `exception` is never high for more than one consecutive cycle.

## Configuration
- Macro `TRAP_ILLEGAL_EN`.
- Defined: kind 11 traps with cause 2, exactly as above.
- Undefined:
  - kind 11 is accepted in IDLE and consumed in one cycle;
  - no COMMIT, no `exception` pulse, no redirect;
  - state stays IDLE and `busy` stays 0.

## Structure
- Shared package `trap_pkg`:
  - `req_kind` encodings: `KIND_ECALL`, `KIND_EBREAK`, `KIND_MRET`, `KIND_ILLEGAL`.
  - cause constants: `CAUSE_ILLEGAL`=2, `CAUSE_BREAKPOINT`=3, `CAUSE_ECALL_M`=11.
  - state enum `trap_state_t`.
- No sub-module. The block is a single FSM with a latched-request register and a target register.

## Test plan
- ECALL, pc=0x8000_0100, mtvec=0x8000_0400, `redirect_ready`=1:
  - `exception`=1 for exactly one cycle, with cause=11 and `exception_pc`=0x8000_0100;
  - next cycle `redirect_valid`=1 with `redirect_pc`=0x8000_0400;
  - `busy` high for 2 cycles.
- MRET, mepc=0x8000_0104: no `exception`; `redirect_valid`=1 one cycle after accept with `redirect_pc`=0x8000_0104.
- EBREAK, mtvec=0x8000_0403, `redirect_ready` low for 3 cycles:
  - cause=3;
  - `redirect_pc`=0x8000_0400, held stable for 4 cycles;
  - return to IDLE after `ready`.
- A second `req_valid` asserted during REDIRECT is not accepted until the cycle after the handshake; its `exception` pulse follows one cycle later.
- `rst_n` dropped in the COMMIT cycle: at that edge all outputs return to 0 and `req_ready`=1; no redirect is ever issued.
- ILLEGAL, pc=0x8000_0200:
  - with `TRAP_ILLEGAL_EN`: cause=2 and `exception_pc`=0x8000_0200;
  - without: `exception` stays 0, `redirect_valid` stays 0, `busy` stays 0.
